// File: rtl/seven_seg_capture_pkg.sv
// Shared definitions for the seven-segment display capture block.
//
// Contents:
//   - segment patterns for digits 0-9 (bit6 = A ... bit0 = G, active-high)
//   - active-low digit select codes for digit1 (rightmost) .. digit4
//   - frame assembly FSM state type
//   - INVALID_DIGIT marker and the minutes:seconds helper used when
//     SEVEN_SEG_CAPTURE_TIME_EN is defined
package seven_seg_capture_pkg;

    localparam int unsigned SAMPLE_W = 12;  // {sel_n[3:0], seg[6:0], dp}

    localparam logic [3:0] INVALID_DIGIT = 4'hF;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [3:0] SEL_DIGIT1 = 4'b1110;
    localparam logic [3:0] SEL_DIGIT2 = 4'b1101;
    localparam logic [3:0] SEL_DIGIT3 = 4'b1011;
    localparam logic [3:0] SEL_DIGIT4 = 4'b0111;

    localparam logic [12:0] TOTAL_SEC_INVALID = 13'h1FFF;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StCollect
    } state_e;

    // Display reads MM:SS as {digit4 digit3 : digit2 digit1}.
    function automatic logic [12:0] digits_to_seconds(input logic [15:0] digits);
        logic [12:0] mins;
        logic [12:0] secs;
        if (digits[15:12] == INVALID_DIGIT || digits[11:8] == INVALID_DIGIT ||
            digits[7:4] == INVALID_DIGIT || digits[3:0] == INVALID_DIGIT) begin
            return TOTAL_SEC_INVALID;
        end
        mins = 13'(digits[15:12]) * 13'd10 + 13'(digits[11:8]);
        secs = 13'(digits[7:4]) * 13'd10 + 13'(digits[3:0]);
        return mins * 13'd60 + secs;
    endfunction

endpackage

// File: rtl/seven_seg_capture_seg_decode.sv
// Combinational seven-segment pattern decoder.
//
// Ports:
//   seg_i      7-bit segment pattern, bit6 = A ... bit0 = G
//   value_o    decoded digit 0-9, INVALID_DIGIT for any other pattern
//   invalid_o  high when the pattern is not one of the ten digit shapes
module seven_seg_capture_seg_decode
    import seven_seg_capture_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] value_o,
    output logic       invalid_o
);

    always_comb begin
        value_o   = INVALID_DIGIT;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_0:   value_o = 4'd0;
            SEG_1:   value_o = 4'd1;
            SEG_2:   value_o = 4'd2;
            SEG_3:   value_o = 4'd3;
            SEG_4:   value_o = 4'd4;
            SEG_5:   value_o = 4'd5;
            SEG_6:   value_o = 4'd6;
            SEG_7:   value_o = 4'd7;
            SEG_8:   value_o = 4'd8;
            SEG_9:   value_o = 4'd9;
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures the frame shown on a multiplexed 4-digit seven-segment display by
// snooping its digit-select, segment and decimal-point lines.
//
// Inputs pass through a 2-flop synchronizer. A sample must hold unchanged for
// STABLE_CYCLES cycles before it is accepted (once per stable period). Accepted
// samples with a single select low are decoded and assembled digit1..digit4
// into a shadow frame, which is published as a whole.
//
// Optional feature: define SEVEN_SEG_CAPTURE_TIME_EN to add total_sec_o, the
// published frame read as MM:SS and converted to seconds.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   sel_n_i[3:0]   digit selects, active-low, bit0 = digit1
//   seg_i[6:0]     segments, active-high, bit6 = A ... bit0 = G
//   dp_i           decimal point, active-high
//   digits_o       last complete frame {digit4, digit3, digit2, digit1}
//   dp_mask_o      decimal points of the last complete frame, bit0 = digit1
//   frame_valid_o  one-cycle pulse when digits_o/dp_mask_o update
//   alive_o        high while accepted samples keep arriving
//   seg_err_o      pulse on acceptance of an undecodable segment pattern
//   seq_err_o      pulse on an out-of-order digit select
//   total_sec_o    (SEVEN_SEG_CAPTURE_TIME_EN only) seconds of the last frame
module seven_seg_capture
    import seven_seg_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  sel_n_i,
    input  logic [6:0]  seg_i,
    input  logic        dp_i,
    output logic [15:0] digits_o,
    output logic [3:0]  dp_mask_o,
    output logic        frame_valid_o,
    output logic        alive_o,
    output logic        seg_err_o,
    output logic        seq_err_o
`ifdef SEVEN_SEG_CAPTURE_TIME_EN
    ,
    output logic [12:0] total_sec_o
`endif
);

    localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYCLES);
    localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // Input synchronizer and stability filter
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] sync1_q, sync2_q, sample_prev_q;
    logic [StabW-1:0]    stab_cnt_q, stab_cnt_d;
    logic                sample_changed;
    logic                accept;

    assign sample_changed = (sync2_q != sample_prev_q);

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (sample_changed) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != StabMax) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    // Fires only on the step into saturation, so one stable period yields a
    // single acceptance.
    assign accept = !sample_changed && (stab_cnt_q == StabMax - 1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            sample_prev_q <= '0;
            stab_cnt_q    <= '0;
        end else begin
            sync1_q       <= {sel_n_i, seg_i, dp_i};
            sync2_q       <= sync1_q;
            sample_prev_q <= sync2_q;
            stab_cnt_q    <= stab_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Accepted sample fields
    // ------------------------------------------------------------------
    logic [3:0] acc_sel_n;
    logic [6:0] acc_seg;
    logic       acc_dp;
    logic       sel_valid;
    logic [1:0] sel_idx;      // 0 = digit1 ... 3 = digit4
    logic [3:0] dec_value;
    logic       dec_invalid;

    assign acc_sel_n = sync2_q[11:8];
    assign acc_seg   = sync2_q[7:1];
    assign acc_dp    = sync2_q[0];

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (acc_sel_n)
            SEL_DIGIT1: sel_idx = 2'd0;
            SEL_DIGIT2: sel_idx = 2'd1;
            SEL_DIGIT3: sel_idx = 2'd2;
            SEL_DIGIT4: sel_idx = 2'd3;
            default:    sel_valid = 1'b0;
        endcase
    end

    seven_seg_capture_seg_decode u_seg_decode (
        .seg_i     (acc_seg),
        .value_o   (dec_value),
        .invalid_o (dec_invalid)
    );

    // ------------------------------------------------------------------
    // Liveness timeout
    // ------------------------------------------------------------------
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           timeout_hit;

    // Any acceptance counts as activity, even with an unusable select.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (accept) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != ToMax) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = !accept && (to_cnt_q == ToMax - 1'b1);

    // ------------------------------------------------------------------
    // Frame assembly
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [1:0]      expect_q, expect_d;    // index of the next digit wanted
    logic [3:0][3:0] shadow_val_q, shadow_val_d;
    logic [3:0]      shadow_dp_q, shadow_dp_d;
    logic [15:0]     digits_q, digits_d;
    logic [3:0]      dp_mask_q, dp_mask_d;
    logic            frame_valid_q, frame_valid_d;
    logic            alive_q, alive_d;
    logic            seg_err_q, seg_err_d;
    logic            seq_err_q, seq_err_d;
    logic            valid_accept;

    assign valid_accept = accept && sel_valid;

    always_comb begin
        state_d       = state_q;
        expect_d      = expect_q;
        shadow_val_d  = shadow_val_q;
        shadow_dp_d   = shadow_dp_q;
        digits_d      = digits_q;
        dp_mask_d     = dp_mask_q;
        frame_valid_d = 1'b0;
        seq_err_d     = 1'b0;
        seg_err_d     = valid_accept && dec_invalid;

        alive_d = alive_q;
        if (accept) begin
            alive_d = 1'b1;
        end else if (timeout_hit) begin
            alive_d = 1'b0;
        end

        if (timeout_hit) begin
            // Partial frame is dropped by leaving COLLECT; published outputs hold.
            state_d = StIdle;
        end else if (valid_accept) begin
            case (state_q)
                StIdle: begin
                    state_d = StSync;
                end
                StSync: begin
                    if (sel_idx == 2'd0) begin
                        shadow_val_d[0] = dec_value;
                        shadow_dp_d[0]  = acc_dp;
                        expect_d        = 2'd1;
                        state_d         = StCollect;
                    end
                end
                StCollect: begin
                    if (sel_idx == expect_q) begin
                        shadow_val_d[sel_idx] = dec_value;
                        shadow_dp_d[sel_idx]  = acc_dp;
                        if (expect_q == 2'd3) begin
                            digits_d = {dec_value, shadow_val_q[2], shadow_val_q[1],
                                        shadow_val_q[0]};
                            dp_mask_d     = {acc_dp, shadow_dp_q[2:0]};
                            frame_valid_d = 1'b1;
                            state_d       = StSync;
                        end else begin
                            expect_d = expect_q + 2'd1;
                        end
                    end else if (sel_idx == expect_q - 2'd1) begin
                        // Same digit refreshed with new content: keep the newest.
                        shadow_val_d[sel_idx] = dec_value;
                        shadow_dp_d[sel_idx]  = acc_dp;
                    end else begin
                        seq_err_d = 1'b1;
                        if (sel_idx == 2'd0) begin
                            shadow_val_d[0] = dec_value;
                            shadow_dp_d[0]  = acc_dp;
                            expect_d        = 2'd1;
                        end else begin
                            state_d = StSync;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q      <= '0;
            state_q       <= StIdle;
            expect_q      <= 2'd1;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            digits_q      <= '0;
            dp_mask_q     <= '0;
            frame_valid_q <= 1'b0;
            alive_q       <= 1'b0;
            seg_err_q     <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            state_q       <= state_d;
            expect_q      <= expect_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            digits_q      <= digits_d;
            dp_mask_q     <= dp_mask_d;
            frame_valid_q <= frame_valid_d;
            alive_q       <= alive_d;
            seg_err_q     <= seg_err_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign digits_o      = digits_q;
    assign dp_mask_o     = dp_mask_q;
    assign frame_valid_o = frame_valid_q;
    assign alive_o       = alive_q;
    assign seg_err_o     = seg_err_q;
    assign seq_err_o     = seq_err_q;

`ifdef SEVEN_SEG_CAPTURE_TIME_EN
    // ------------------------------------------------------------------
    // MM:SS to seconds, one cycle behind the frame it describes
    // ------------------------------------------------------------------
    logic [12:0] total_sec_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            total_sec_q <= '0;
        end else if (frame_valid_q) begin
            total_sec_q <= digits_to_seconds(digits_q);
        end
    end

    assign total_sec_o = total_sec_q;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed display scans plus a
// randomized scan phase, every cycle compared against a behavioural model.
module tb_seven_seg_capture;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 8192;

    logic        clk;
    logic        rst;
    logic [3:0]  sel_n;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        frame_valid, alive, seg_err, seq_err;
`ifdef SEVEN_SEG_CAPTURE_TIME_EN
    logic [12:0] total_sec;
`endif

    seven_seg_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sel_n_i       (sel_n),
        .seg_i         (seg),
        .dp_i          (dp),
        .digits_o      (digits),
        .dp_mask_o     (dp_mask),
        .frame_valid_o (frame_valid),
        .alive_o       (alive),
        .seg_err_o     (seg_err),
        .seq_err_o     (seq_err)
`ifdef SEVEN_SEG_CAPTURE_TIME_EN
        ,
        .total_sec_o   (total_sec)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fv_cnt, seg_cnt, seq_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int decode_seg(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (seg_of(i) == p) return i;
        return 15;
    endfunction

    function automatic int which_digit(input logic [3:0] s);
        case (s)
            4'b1110: return 1;
            4'b1101: return 2;
            4'b1011: return 3;
            4'b0111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [12:0] seconds_of(input logic [15:0] d);
        int d4, d3, d2, d1;
        d4 = int'(d[15:12]); d3 = int'(d[11:8]); d2 = int'(d[7:4]); d1 = int'(d[3:0]);
        if (d4 == 15 || d3 == 15 || d2 == 15 || d1 == 15) return 13'h1FFF;
        return 13'((d4 * 10 + d3) * 60 + d2 * 10 + d1);
    endfunction

    // The model sees inputs two clocks late (synchronizer), accepts a value
    // when it has been seen unchanged for exactly STABLE consecutive clocks.
    logic [11:0] m_pipe0, m_pipe1, m_prev;
    int          m_run, m_idle, m_phase;   // phase 0 idle, 1 hunting digit1, 2..4 wanted digit
    int          m_slot [1:4];
    logic        m_sdp  [1:4];
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic        m_fv, m_seg_err, m_seq_err, m_alive;
    logic [12:0] m_total;

    task automatic put(input int d, input int v, input logic p);
        m_slot[d] = v;
        m_sdp[d]  = p;
    endtask

    task automatic model_step();
        logic [11:0] s;
        bit acc;
        int d, v;
        if (rst) begin
            m_pipe0 = '0; m_pipe1 = '0; m_prev = '0;
            m_run = 0; m_idle = 0; m_phase = 0;
            m_digits = '0; m_dp = '0; m_total = '0;
            m_fv = 0; m_seg_err = 0; m_seq_err = 0; m_alive = 0;
            return;
        end
        s = m_pipe1;
        m_pipe1 = m_pipe0;
        m_pipe0 = {sel_n, seg, dp};
        if (m_fv) m_total = seconds_of(m_digits);
        m_fv = 0; m_seg_err = 0; m_seq_err = 0; acc = 0;
        if (s == m_prev) begin
            if (m_run < STABLE) begin
                m_run++;
                acc = (m_run == STABLE);
            end
        end else begin
            m_run = 0;
        end
        m_prev = s;
        if (acc) begin
            m_idle = 0;
            m_alive = 1;
        end else if (m_idle < TIMEOUT) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_alive = 0;
                m_phase = 0;
            end
        end
        if (!acc) return;
        d = which_digit(s[11:8]);
        if (d == 0) return;
        v = decode_seg(s[7:1]);
        if (v == 15) m_seg_err = 1;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (d == 1) begin
                put(1, v, s[0]);
                m_phase = 2;
            end
        end else if (d == m_phase) begin
            put(d, v, s[0]);
            if (d == 4) begin
                m_digits = {4'(m_slot[4]), 4'(m_slot[3]), 4'(m_slot[2]), 4'(m_slot[1])};
                m_dp = {m_sdp[4], m_sdp[3], m_sdp[2], m_sdp[1]};
                m_fv = 1;
                m_phase = 1;
            end else begin
                m_phase++;
            end
        end else if (d == m_phase - 1) begin
            put(d, v, s[0]);
        end else begin
            m_seq_err = 1;
            if (d == 1) begin
                put(1, v, s[0]);
                m_phase = 2;
            end else begin
                m_phase = 1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("digits", 32'(digits), 32'(m_digits));
        check("dp_mask", 32'(dp_mask), 32'(m_dp));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("alive", 32'(alive), 32'(m_alive));
        check("seg_err", 32'(seg_err), 32'(m_seg_err));
        check("seq_err", 32'(seq_err), 32'(m_seq_err));
`ifdef SEVEN_SEG_CAPTURE_TIME_EN
        check("total_sec", 32'(total_sec), 32'(m_total));
`endif
        if (frame_valid === 1'b1) fv_cnt++;
        if (seg_err === 1'b1) seg_cnt++;
        if (seq_err === 1'b1) seq_cnt++;
    endtask

    task automatic clear_counts();
        fv_cnt = 0; seg_cnt = 0; seq_cnt = 0;
    endtask

    task automatic hold(input logic [3:0] s, input logic [6:0] g, input logic d, input int n);
        sel_n = s; seg = g; dp = d;
        repeat (n) tick();
    endtask

    // Scans digit1..digit4; optional glitch precedes each digit.
    task automatic scan(input logic [6:0] p4, input logic [6:0] p3, input logic [6:0] p2,
                        input logic [6:0] p1, input logic [3:0] dpm, input int dwell,
                        input int glitch);
        if (glitch > 0) hold(4'b1110, 7'b0000001, 1'b0, glitch);
        hold(4'b1110, p1, dpm[0], dwell);
        if (glitch > 0) hold(4'b1101, 7'b0000001, 1'b0, glitch);
        hold(4'b1101, p2, dpm[1], dwell);
        if (glitch > 0) hold(4'b1011, 7'b0000001, 1'b0, glitch);
        hold(4'b1011, p3, dpm[2], dwell);
        if (glitch > 0) hold(4'b0111, 7'b0000001, 1'b0, glitch);
        hold(4'b0111, p4, dpm[3], dwell);
    endtask

    initial begin
        int waited;
        rst = 1'b1; sel_n = 4'hF; seg = '0; dp = 1'b0;
        clear_counts();
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp_mask", 32'(dp_mask), 32'h0);
        check("rst_alive", 32'(alive), 32'h0);

        // Slow scan of 1 2 4 3 (digit4..digit1), DP on digit3.
        clear_counts();
        scan(seg_of(1), seg_of(2), seg_of(4), seg_of(3), 4'b0100, 1024, 0);
        scan(seg_of(1), seg_of(2), seg_of(4), seg_of(3), 4'b0100, 1024, 0);
        check("slow_first_frame_cnt", 32'(fv_cnt), 32'd1);
        clear_counts();
        scan(seg_of(1), seg_of(2), seg_of(4), seg_of(3), 4'b0100, 1024, 0);
        check("slow_frame_cnt", 32'(fv_cnt), 32'd1);
        check("slow_digits", 32'(digits), 32'h1243);
        check("slow_dp_mask", 32'(dp_mask), 32'h4);
        check("slow_alive", 32'(alive), 32'h1);

        // Short glitches are filtered out.
        clear_counts();
        scan(seg_of(1), seg_of(2), seg_of(4), seg_of(3), 4'b0100, 64, 10);
        check("glitch_seg_err_cnt", 32'(seg_cnt), 32'd0);
        check("glitch_frame_cnt", 32'(fv_cnt), 32'd1);
        check("glitch_digits", 32'(digits), 32'h1243);

        // Undecodable digit2.
        clear_counts();
        scan(seg_of(1), seg_of(2), 7'b0000001, seg_of(3), 4'b0000, 64, 0);
        check("bad_seg_err_cnt", 32'(seg_cnt), 32'd1);
        check("bad_seg_digits", 32'(digits), 32'h12F3);

        // Out-of-order select, then recovery.
        clear_counts();
        hold(4'b1110, seg_of(3), 1'b0, 64);
        hold(4'b1011, seg_of(2), 1'b0, 64);
        check("order_seq_err_cnt", 32'(seq_cnt), 32'd1);
        check("order_frame_cnt", 32'(fv_cnt), 32'd0);
        clear_counts();
        scan(seg_of(1), seg_of(2), seg_of(4), seg_of(3), 4'b0100, 64, 0);
        check("recover_frame_cnt", 32'(fv_cnt), 32'd1);
        check("recover_digits", 32'(digits), 32'h1243);

        // 99:59 as MM:SS.
        scan(seg_of(9), seg_of(9), seg_of(5), seg_of(9), 4'b0000, 64, 0);
        check("time_digits", 32'(digits), 32'h9959);
`ifdef SEVEN_SEG_CAPTURE_TIME_EN
        check("time_total_sec", 32'(total_sec), 32'd5999);
`endif

        // Reset in the middle of a frame.
        hold(4'b1110, seg_of(7), 1'b1, 64);
        hold(4'b1101, seg_of(8), 1'b0, 64);
        clear_counts();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (40) tick();
        check("midrst_frame_cnt", 32'(fv_cnt), 32'd0);
        check("midrst_digits", 32'(digits), 32'h0);
        check("midrst_dp_mask", 32'(dp_mask), 32'h0);
`ifdef SEVEN_SEG_CAPTURE_TIME_EN
        check("midrst_total_sec", 32'(total_sec), 32'd0);
`endif

        // Inputs stop after a frame: alive drops, frame holds.
        scan(seg_of(1), seg_of(2), seg_of(4), seg_of(3), 4'b0100, 64, 0);
        check("pre_timeout_digits", 32'(digits), 32'h1243);
        clear_counts();
        sel_n = 4'hF; seg = '0; dp = 1'b0;
        waited = 0;
        while (alive === 1'b1 && waited < TIMEOUT + 100) begin
            tick();
            waited++;
        end
        check("timeout_alive", 32'(alive), 32'h0);
        check("timeout_in_window", 32'(waited >= TIMEOUT && waited <= TIMEOUT + 40), 32'h1);
        check("timeout_digits_hold", 32'(digits), 32'h1243);
        check("timeout_dp_hold", 32'(dp_mask), 32'h4);
        check("timeout_no_frame", 32'(fv_cnt), 32'd0);

        // Randomized scans with reorders, glitches, bad patterns and resets.
        for (int it = 0; it < 100; it++) begin
            int kind;
            int order [4];
            kind = $urandom_range(0, 9);
            for (int k = 0; k < 4; k++) order[k] = k + 1;
            if (kind == 0) begin
                int a, b, t;
                a = $urandom_range(0, 3);
                b = $urandom_range(0, 3);
                t = order[a]; order[a] = order[b]; order[b] = t;
            end
            for (int k = 0; k < 4; k++) begin
                logic [3:0] s;
                logic [6:0] p;
                s = 4'b1111;
                s[order[k] - 1] = 1'b0;
                if (kind == 1 && k == 2) begin
                    rst = 1'b1;
                    tick(); tick();
                    rst = 1'b0;
                end
                if (kind == 2 && k == 1) s = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 11) == 0) p = 7'($urandom);
                else p = seg_of($urandom_range(0, 9));
                if ($urandom_range(0, 3) == 0)
                    hold(s, 7'($urandom), 1'($urandom), $urandom_range(1, 15));
                hold(s, p, 1'($urandom), $urandom_range(8, 60));
            end
            if (kind == 3) hold(4'hF, 7'h00, 1'b0, $urandom_range(20, 200));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
